// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: reset values for the stack and global pointers,
// the default data width and the register-index type.
package cpu_pkg;

  localparam int CPU_XLEN = 32;
  localparam int CPU_NREG = 32;

  localparam logic [31:0] STACK_INIT = 32'h0001_0000;
  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;

  typedef logic [$clog2(CPU_NREG)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on accepted issue,
// cleared on writeback, wiped by flush; also answers per-read-port hazard queries.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = CPU_NREG,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  output logic [NRD-1:0]          rd_hazard,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  output logic                    iss_ok,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic                    flush,
  output logic [NREG-1:0]         busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // A writeback landing this cycle frees the register, so a new issue may claim it.
  always_comb begin
    iss_ok = iss_en && !flush &&
             ((iss_addr == '0) || !busy_q[iss_addr] || (wr_en && (wr_addr == iss_addr)));
  end

  // Applied in ascending priority: clear, then issue-set, then flush.
  always_comb begin
    busy_d = busy_q;
    if (wr_en && (wr_addr != '0)) busy_d[wr_addr] = 1'b0;
    if (iss_ok && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rd_hazard = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_hazard[i] = busy_q[rd_addr[i]] && !(wr_en && (wr_addr == rd_addr[i])) &&
                     (rd_addr[i] != '0);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one bypassed write port,
// a pending-write scoreboard and a registered write-first debug read port.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int NREG = CPU_NREG,
  parameter int NRD  = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(STACK_INIT),
  parameter logic [XLEN-1:0] GP_INIT = XLEN'(MMIO_BASE),
  localparam int AW  = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_hazard,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_ok,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     flush,
  input  logic [AW-1:0]            dbg_addr,
  output logic [XLEN-1:0]          dbg_data
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] dbg_q;
  logic [XLEN-1:0] dbg_d;
  logic [NREG-1:0] busy;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  // Debug reads the post-write array so a same-edge write is visible.
  always_comb begin
    dbg_d = (dbg_addr == '0) ? '0 : regs_d[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      regs_q[2] <= SP_INIT;
      regs_q[3] <= GP_INIT;
      dbg_q     <= '0;
    end else begin
      regs_q <= regs_d;
      dbg_q  <= dbg_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i] == '0)                      rd_data[i] = '0;
      else if (wr_en && (wr_addr == rd_addr[i])) rd_data[i] = wr_data;
      else                                       rd_data[i] = regs_q[rd_addr[i]];
    end
  end

  assign dbg_data = dbg_q;

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_hazard (rd_hazard),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ok    (iss_ok),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .flush     (flush),
    .busy      (busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32/2-port instance plus a 16x64/3-port instance.
module tb_regfile_sb;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic [1:0][4:0]  rd_addr_a;
  logic [1:0][31:0] rd_data_a;
  logic [1:0]       rd_hazard_a;
  logic             iss_en_a, iss_ok_a, wr_en_a, flush_a;
  logic [4:0]       iss_addr_a, wr_addr_a, dbg_addr_a;
  logic [31:0]      wr_data_a, dbg_data_a;

  // Instance B: parameter sweep
  logic [2:0][3:0]  rd_addr_b;
  logic [2:0][63:0] rd_data_b;
  logic [2:0]       rd_hazard_b;
  logic             iss_en_b, iss_ok_b, wr_en_b, flush_b;
  logic [3:0]       iss_addr_b, wr_addr_b, dbg_addr_b;
  logic [63:0]      wr_data_b, dbg_data_b;

  regfile_sb dut_a (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_hazard(rd_hazard_a),
    .iss_en(iss_en_a), .iss_addr(iss_addr_a), .iss_ok(iss_ok_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .flush(flush_a), .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) dut_b (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_hazard(rd_hazard_b),
    .iss_en(iss_en_b), .iss_addr(iss_addr_b), .iss_ok(iss_ok_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .flush(flush_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
  );

  logic [63:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Advance one clock, then settle just past the edge before driving/checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    iss_en_a = 1'b0; wr_en_a = 1'b0; flush_a = 1'b0;
  endtask

  logic [4:0]  ra;
  logic [31:0] rv;

  initial begin
    reset = 1'b0;
    rd_addr_a = '0; iss_en_a = 0; iss_addr_a = '0; wr_en_a = 0; wr_addr_a = '0;
    wr_data_a = '0; flush_a = 0; dbg_addr_a = '0;
    rd_addr_b = '0; iss_en_b = 0; iss_addr_b = '0; wr_en_b = 0; wr_addr_b = '0;
    wr_data_b = '0; flush_b = 0; dbg_addr_b = '0;

    // Reset held two cycles, ignoring write/issue/flush traffic
    step();
    wr_en_a = 1; wr_addr_a = 5'd5; wr_data_a = 32'h1234; iss_en_a = 1; iss_addr_a = 5'd5;
    step();
    idle_a();
    reset = 1'b1;
    rd_addr_a[0] = 5'd2; rd_addr_a[1] = 5'd3;
    #1;
    expect_val(64'(STACK_INIT)); check("reset_x2", rd_data_a[0]);
    expect_val(64'(MMIO_BASE));  check("reset_x3", rd_data_a[1]);
    rd_addr_a[0] = 5'd5; rd_addr_a[1] = 5'd9;
    #1;
    expect_val(64'd0); check("reset_x5", rd_data_a[0]);
    expect_val(64'd0); check("reset_hazard", rd_hazard_a);
    expect_val(64'd0); check("reset_dbg", dbg_data_a);

    // Write and same-cycle bypass
    wr_en_a = 1; wr_addr_a = 5'd7; wr_data_a = 32'hDEADBEEF; rd_addr_a[0] = 5'd7;
    #1;
    expect_val(64'hDEADBEEF); check("bypass_x7", rd_data_a[0]);
    step();
    idle_a();
    #1;
    expect_val(64'hDEADBEEF); check("array_x7", rd_data_a[0]);
    wr_en_a = 1; wr_addr_a = 5'd0; wr_data_a = 32'd5; rd_addr_a[0] = 5'd0;
    #1;
    expect_val(64'd0); check("x0_bypass", rd_data_a[0]);
    step();
    idle_a();
    #1;
    expect_val(64'd0); check("x0_array", rd_data_a[0]);

    // Scoreboard: issue, hazard, WAW refusal, writeback clear
    iss_en_a = 1; iss_addr_a = 5'd9;
    #1;
    expect_val(64'd1); check("iss_x9", iss_ok_a);
    step();
    rd_addr_a[0] = 5'd9;
    #1;
    expect_val(64'd1); check("haz_x9", rd_hazard_a[0]);
    expect_val(64'd0); check("waw_x9", iss_ok_a);
    iss_en_a = 0; wr_en_a = 1; wr_addr_a = 5'd9; wr_data_a = 32'h42;
    #1;
    expect_val(64'd0);  check("haz_x9_wb", rd_hazard_a[0]);
    expect_val(64'h42); check("data_x9_wb", rd_data_a[0]);
    step();
    idle_a();
    #1;
    expect_val(64'd0);  check("haz_x9_after", rd_hazard_a[0]);
    expect_val(64'h42); check("data_x9_after", rd_data_a[0]);

    // x0 issue always accepted, never busy
    iss_en_a = 1; iss_addr_a = 5'd0; rd_addr_a[1] = 5'd0;
    #1;
    expect_val(64'd1); check("iss_x0", iss_ok_a);
    step();
    idle_a();
    #1;
    expect_val(64'd0); check("haz_x0", rd_hazard_a[1]);

    // Same-register writeback plus issue: issue wins
    iss_en_a = 1; iss_addr_a = 5'd4;
    step();
    wr_en_a = 1; wr_addr_a = 5'd4; wr_data_a = 32'h11; rd_addr_a[0] = 5'd4;
    #1;
    expect_val(64'd1); check("wb_iss_ok", iss_ok_a);
    step();
    idle_a();
    #1;
    expect_val(64'd1);  check("wb_iss_haz", rd_hazard_a[0]);
    expect_val(64'h11); check("wb_iss_data", rd_data_a[0]);

    // Flush with concurrent issue and writeback
    iss_en_a = 1; iss_addr_a = 5'd1; step();
    iss_addr_a = 5'd2; step();
    iss_addr_a = 5'd31; step();
    rd_addr_a[0] = 5'd1; rd_addr_a[1] = 5'd31; iss_en_a = 0;
    #1;
    expect_val(64'd3); check("pre_flush_haz", rd_hazard_a);
    flush_a = 1; iss_en_a = 1; iss_addr_a = 5'd5;
    wr_en_a = 1; wr_addr_a = 5'd1; wr_data_a = 32'd3;
    #1;
    expect_val(64'd0); check("flush_iss_ok", iss_ok_a);
    step();
    idle_a();
    #1;
    expect_val(64'd0); check("flush_haz_1_31", rd_hazard_a);
    expect_val(64'd3); check("flush_x1", rd_data_a[0]);
    rd_addr_a[0] = 5'd2; rd_addr_a[1] = 5'd5;
    #1;
    expect_val(64'd0); check("flush_haz_2_5", rd_hazard_a);
    rd_addr_a[0] = 5'd4;
    #1;
    expect_val(64'd0); check("flush_haz_4", rd_hazard_a[0]);

    // Debug port: write-first, and x0 reads 0
    wr_en_a = 1; wr_addr_a = 5'd10; wr_data_a = 32'hA5A5_5A5A; dbg_addr_a = 5'd10;
    step();
    idle_a();
    #1;
    expect_val(64'hA5A5_5A5A); check("dbg_write_first", dbg_data_a);
    dbg_addr_a = 5'd0;
    step();
    expect_val(64'd0); check("dbg_x0", dbg_data_a);

    // Randomised write/readback through array and debug port
    for (int i = 0; i < 8; i++) begin
      ra = 5'($urandom_range(1, 31));
      rv = $urandom;
      wr_en_a = 1; wr_addr_a = ra; wr_data_a = rv; dbg_addr_a = ra;
      expect_val(64'(rv)); expect_val(64'(rv));
      step();
      idle_a();
      rd_addr_a[1] = ra;
      #1;
      check("rand_array", rd_data_a[1]);
      check("rand_dbg", dbg_data_a);
    end

    // Reset mid-operation drops pending marks and register contents
    iss_en_a = 1; iss_addr_a = 5'd6; step();
    idle_a();
    reset = 1'b0; step();
    reset = 1'b1;
    rd_addr_a[0] = 5'd6; rd_addr_a[1] = 5'd7;
    #1;
    expect_val(64'd0); check("rst_mid_haz", rd_hazard_a);
    expect_val(64'd0); check("rst_mid_x7", rd_data_a[1]);

    // Parameter sweep instance
    rd_addr_b[0] = 4'd2;
    #1;
    expect_val(64'(STACK_INIT)); check("b_reset_x2", rd_data_b[0]);
    rd_addr_b[0] = 4'd15; rd_addr_b[1] = 4'd15; rd_addr_b[2] = 4'd15;
    wr_en_b = 1; wr_addr_b = 4'd15; wr_data_b = 64'hFFFF_FFFF_FFFF_FFFF; dbg_addr_b = 4'd15;
    #1;
    expect_val(64'hFFFF_FFFF_FFFF_FFFF); check("b_bypass_p2", rd_data_b[2]);
    step();
    wr_en_b = 0;
    #1;
    for (int p = 0; p < 3; p++) begin
      expect_val(64'hFFFF_FFFF_FFFF_FFFF); check("b_read_x15", rd_data_b[p]);
    end
    expect_val(64'hFFFF_FFFF_FFFF_FFFF); check("b_dbg_x15", dbg_data_b);
    iss_en_b = 1; iss_addr_b = 4'd15;
    step();
    iss_en_b = 0;
    #1;
    expect_val(64'd7); check("b_haz_all", rd_hazard_b);

    if (exp_q.size() != 0) begin
      total_cnt++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
